// File: rtl/pc_fetch_ctrl.sv
// pc_fetch_ctrl: program-counter register and instruction-fetch sequencer.
// Holds the PC, exports PC+INSTR_BYTES for the branch-select mux, and issues
// one req/ready fetch per PC with stall and misaligned-target handling.
// Optional build macro FETCH_COUNTER_EN adds a 32-bit accepted-fetch counter;
// without it fetchCount reads constant 0.
module pc_fetch_ctrl #(
  parameter int              PC_WIDTH    = 32,
  parameter logic [PC_WIDTH-1:0] RESET_PC = '0,
  parameter int              INSTR_BYTES = 4
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [PC_WIDTH-1:0] PCNext,
  input  logic                stall,
  input  logic                imemReady,
  output logic [PC_WIDTH-1:0] PC,
  output logic [PC_WIDTH-1:0] PCPlus4,
  output logic                imemReq,
  output logic [PC_WIDTH-1:0] imemAddr,
  output logic                fetchValid,
  output logic                misaligned,
  output logic [31:0]         fetchCount
);

  typedef enum logic [1:0] {BOOT, FETCH, STALLED, HALT_ERR} state_t;

  localparam logic [PC_WIDTH-1:0] ALIGN_MASK = PC_WIDTH'(INSTR_BYTES - 1);
  localparam logic [PC_WIDTH-1:0] STEP       = PC_WIDTH'(INSTR_BYTES);

  state_t state, state_nx;
  logic   accept;
  logic   bad_target;

  assign PCPlus4    = PC + STEP;
  assign imemAddr   = PC;
  assign accept     = imemReq & imemReady;
  // Mask form also covers INSTR_BYTES == 1, where no low bits exist.
  assign bad_target = |(PCNext & ALIGN_MASK);

  // Next-state and request decode; stall suppresses the request immediately.
  always_comb begin
    state_nx = state;
    imemReq  = 1'b0;
    case (state)
      BOOT:     state_nx = FETCH;
      FETCH: begin
        imemReq = !stall;
        if (stall)
          state_nx = STALLED;
        else if (imemReady && bad_target)
          state_nx = HALT_ERR;
      end
      STALLED:  if (!stall) state_nx = FETCH;
      HALT_ERR: state_nx = HALT_ERR;
      default:  state_nx = BOOT;
    endcase
  end

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= BOOT;
    else       state <= state_nx;
  end

  // PC update, accept pulse and sticky misalignment flag.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      PC         <= RESET_PC;
      fetchValid <= 1'b0;
      misaligned <= 1'b0;
    end else begin
      fetchValid <= accept;
      if (accept) begin
        if (bad_target) misaligned <= 1'b1;
        else            PC         <= PCNext;
      end
    end
  end

`ifdef FETCH_COUNTER_EN
  logic [31:0] fetch_cnt;

  // Accepted-fetch counter, wraps naturally at 2^32.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)       fetch_cnt <= '0;
    else if (accept) fetch_cnt <= fetch_cnt + 32'd1;
  end

  assign fetchCount = fetch_cnt;
`else
  assign fetchCount = '0;
`endif

endmodule
